// File: rtl/qdec_pkg.sv
// Shared types and the Gray-phase step decoder for the quadrature decoder.
package qdec_pkg;

   typedef logic [1:0] phase_t;

   localparam phase_t PH_00 = 2'b00;
   localparam phase_t PH_01 = 2'b01;
   localparam phase_t PH_11 = 2'b11;
   localparam phase_t PH_10 = 2'b10;

   // Classifies a phase transition. Result is {up, down}:
   // 00 = no change, 10 = forward step, 01 = reverse step, 11 = illegal jump.
   function automatic logic [1:0] step_dec(phase_t old, phase_t nw);
      phase_t fwd;
      phase_t rev;
      logic [1:0] res;
      fwd = PH_00;
      rev = PH_00;
      case (old)
         PH_00:   begin fwd = PH_01; rev = PH_10; end
         PH_01:   begin fwd = PH_11; rev = PH_00; end
         PH_11:   begin fwd = PH_10; rev = PH_01; end
         PH_10:   begin fwd = PH_00; rev = PH_11; end
         default: begin fwd = PH_00; rev = PH_00; end
      endcase
      if (nw == old)
         res = 2'b00;
      else if (nw == fwd)
         res = 2'b10;
      else if (nw == rev)
         res = 2'b01;
      else
         res = 2'b11;
      return res;
   endfunction

endpackage

// File: rtl/debounce_filter.sv
// Single-channel level filter: a new level is accepted only after it has been
// sampled CYCLES times in a row; shorter excursions are absorbed.
module debounce_filter #(
   parameter int CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout,
   output logic stable
);

   localparam int CNT_W = $clog2(CYCLES + 1);

   logic [CNT_W-1:0] cnt;

   // Count consecutive samples that disagree with the filtered level; accept on the last one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         dout <= 1'b0;
      end else if (din == dout) begin
         cnt <= '0;
      end else if (cnt == CNT_W'(CYCLES - 1)) begin
         dout <= din;
         cnt  <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Stable means no level change is in progress on this channel.
   assign stable = (din == dout);

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature front end: synchronises and debounces A/B, primes the phase
// register after reset, then turns each Gray-code step into one up/down strobe
// and flags two-bit jumps with a sticky error.
//
// Handshake: none. up/down are single-cycle registered strobes with no
// back-pressure; err_clr is a single-cycle request sampled on the rising edge.
module quadrature_decoder
   import qdec_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enc_a,
   input  logic enc_b,
   input  logic err_clr,
   output logic up,
   output logic down,
   output logic dir,
   output logic err,
   output logic primed
);

   logic [SYNC_STAGES-1:0] sync_a;
   logic [SYNC_STAGES-1:0] sync_b;
   logic [SYNC_STAGES-1:0] sync_full;
   logic                   filt_a;
   logic                   filt_b;
   logic                   stable_a;
   logic                   stable_b;
   phase_t                 phase;
   phase_t                 cur;
   logic [1:0]             dec;

   // Synchroniser chains; sync_full marks when the chains hold real input samples
   // rather than their reset values, so priming never latches a stale 00.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a    <= '0;
         sync_b    <= '0;
         sync_full <= '0;
      end else begin
         sync_a    <= {sync_a[SYNC_STAGES-2:0], enc_a};
         sync_b    <= {sync_b[SYNC_STAGES-2:0], enc_b};
         sync_full <= {sync_full[SYNC_STAGES-2:0], 1'b1};
      end
   end

   debounce_filter #(.CYCLES(DEBOUNCE_CYCLES)) u_filt_a (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (sync_a[SYNC_STAGES-1]),
      .dout   (filt_a),
      .stable (stable_a)
   );

   debounce_filter #(.CYCLES(DEBOUNCE_CYCLES)) u_filt_b (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (sync_b[SYNC_STAGES-1]),
      .dout   (filt_b),
      .stable (stable_b)
   );

   assign cur = {filt_a, filt_b};
   assign dec = step_dec(phase, cur);

   // Priming, phase tracking and strobe/direction generation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         primed <= 1'b0;
         phase  <= PH_00;
         up     <= 1'b0;
         down   <= 1'b0;
         dir    <= 1'b0;
      end else begin
         up   <= 1'b0;
         down <= 1'b0;
         if (!primed) begin
            if (sync_full[SYNC_STAGES-1] && stable_a && stable_b) begin
               primed <= 1'b1;
               phase  <= cur;
            end
         end else begin
            phase <= cur;
            case (dec)
               2'b10: begin
                  up  <= 1'b1;
                  dir <= 1'b1;
               end
               2'b01: begin
                  down <= 1'b1;
                  dir  <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   // Sticky illegal-jump flag; a jump in the same cycle as err_clr keeps it set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err <= 1'b0;
      else if (primed && (dec == 2'b11))
         err <= 1'b1;
      else if (err_clr)
         err <= 1'b0;
   end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder at SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_quadrature_decoder;

   logic clk;
   logic rst_n;
   logic enc_a;
   logic enc_b;
   logic err_clr;
   logic up;
   logic down;
   logic dir;
   logic err;
   logic primed;

   int checks   = 0;
   int failures = 0;

   int cyc = 0;
   int up_cnt = 0;
   int down_cnt = 0;
   int both_cnt = 0;
   int last_up_cyc = 0;
   int last_down_cyc = 0;
   int edge_cyc = 0;
   int up_base;
   int down_base;

   localparam int LAT = 7;

   quadrature_decoder #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .enc_a   (enc_a),
      .enc_b   (enc_b),
      .err_clr (err_clr),
      .up      (up),
      .down    (down),
      .dir     (dir),
      .err     (err),
      .primed  (primed)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // strobe monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (up === 1'b1) begin
         up_cnt++;
         last_up_cyc = cyc;
      end
      if (down === 1'b1) begin
         down_cnt++;
         last_down_cyc = cyc;
      end
      if (up === 1'b1 && down === 1'b1)
         both_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_ab(input logic a, input logic b);
      enc_a    = a;
      enc_b    = b;
      edge_cyc = cyc;
   endtask

   task automatic snap();
      up_base   = up_cnt;
      down_base = down_cnt;
   endtask

   task automatic wait_primed(input int limit);
      for (int i = 0; i < limit; i++) begin
         if (primed === 1'b1) break;
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      enc_a   = 1'b0;
      enc_b   = 1'b0;
      err_clr = 1'b0;

      // 1. reset with A=B=0, then release
      wait_cycles(3);
      check("rst_up", up, 1'b0);
      check("rst_down", down, 1'b0);
      check("rst_dir", dir, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_primed", primed, 1'b0);
      snap();
      rst_n = 1'b1;
      wait_primed(7);
      check("prime_00", primed, 1'b1);
      wait_cycles(10);
      check("prime_no_up", up_cnt - up_base, 0);
      check("prime_no_down", down_cnt - down_base, 0);
      check("prime_err", err, 1'b0);

      // 2. forward sequence 00->01->11->10->00
      snap();
      set_ab(1'b0, 1'b1); wait_cycles(10);
      check("fwd1_cnt", up_cnt - up_base, 1);
      check("fwd1_lat", last_up_cyc - edge_cyc, LAT);
      set_ab(1'b1, 1'b1); wait_cycles(10);
      check("fwd2_cnt", up_cnt - up_base, 2);
      check("fwd2_lat", last_up_cyc - edge_cyc, LAT);
      set_ab(1'b1, 1'b0); wait_cycles(10);
      check("fwd3_cnt", up_cnt - up_base, 3);
      check("fwd3_lat", last_up_cyc - edge_cyc, LAT);
      set_ab(1'b0, 1'b0); wait_cycles(10);
      check("fwd4_wrap_cnt", up_cnt - up_base, 4);
      check("fwd4_lat", last_up_cyc - edge_cyc, LAT);
      check("fwd_dir", dir, 1'b1);
      check("fwd_no_down", down_cnt - down_base, 0);

      // 3. reverse sequence 00->10->11->01->00
      snap();
      set_ab(1'b1, 1'b0); wait_cycles(10);
      check("rev1_cnt", down_cnt - down_base, 1);
      check("rev1_lat", last_down_cyc - edge_cyc, LAT);
      set_ab(1'b1, 1'b1); wait_cycles(10);
      check("rev2_cnt", down_cnt - down_base, 2);
      set_ab(1'b0, 1'b1); wait_cycles(10);
      check("rev3_cnt", down_cnt - down_base, 3);
      set_ab(1'b0, 1'b0); wait_cycles(10);
      check("rev4_cnt", down_cnt - down_base, 4);
      check("rev4_lat", last_down_cyc - edge_cyc, LAT);
      check("rev_dir", dir, 1'b0);
      check("rev_no_up", up_cnt - up_base, 0);

      // 4. 2-cycle glitch on A from phase 00
      snap();
      set_ab(1'b1, 1'b0); wait_cycles(2);
      set_ab(1'b0, 1'b0); wait_cycles(10);
      check("glitch_no_up", up_cnt - up_base, 0);
      check("glitch_no_down", down_cnt - down_base, 0);
      check("glitch_err", err, 1'b0);
      // phase must still be 00: 00->01 is forward, 01->00 is reverse
      set_ab(1'b0, 1'b1); wait_cycles(10);
      check("glitch_then_up", up_cnt - up_base, 1);
      set_ab(1'b0, 1'b0); wait_cycles(10);
      check("glitch_then_down", down_cnt - down_base, 1);

      // 5. illegal jump 00->11, clear, then clear colliding with 11->00
      snap();
      set_ab(1'b1, 1'b1); wait_cycles(10);
      check("jump_err", err, 1'b1);
      check("jump_no_up", up_cnt - up_base, 0);
      check("jump_no_down", down_cnt - down_base, 0);
      err_clr = 1'b1; wait_cycles(1);
      err_clr = 1'b0;
      check("err_cleared", err, 1'b0);
      wait_cycles(3);
      set_ab(1'b0, 1'b0); wait_cycles(LAT - 1);
      err_clr = 1'b1; wait_cycles(1);
      err_clr = 1'b0;
      check("set_wins", err, 1'b1);
      wait_cycles(5);
      check("set_wins_hold", err, 1'b1);
      check("jump2_no_strobe", (up_cnt - up_base) + (down_cnt - down_base), 0);

      // 6. reset at phase 11 with an up strobe pending
      set_ab(1'b0, 1'b1); wait_cycles(10);
      set_ab(1'b1, 1'b1); wait_cycles(3);
      snap();
      rst_n = 1'b0;
      #1;
      check("midrst_up", up, 1'b0);
      check("midrst_dir", dir, 1'b0);
      check("midrst_err", err, 1'b0);
      check("midrst_primed", primed, 1'b0);
      wait_cycles(2);
      rst_n = 1'b1;
      wait_primed(15);
      check("reprime", primed, 1'b1);
      wait_cycles(10);
      check("reprime_no_up", up_cnt - up_base, 0);
      check("reprime_no_down", down_cnt - down_base, 0);
      check("reprime_err", err, 1'b0);
      set_ab(1'b1, 1'b0); wait_cycles(10);
      check("after_rst_up", up_cnt - up_base, 1);
      check("after_rst_lat", last_up_cyc - edge_cyc, LAT);
      check("after_rst_dir", dir, 1'b1);

      check("never_both", both_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
